// File: rtl/adc_input_select.sv
// adc_input_select: multi-ADC front end.
// Registers every ADC bus, routes the selected channel to a left-justified
// two's complement output, inserts a muted gap on channel switches and
// stretches the selected channel's overrange into of_flag.
// Optional peak-magnitude hold is built only when ADC_PEAK_EN is defined.
//
// Switch handshake: sel_req is a single-cycle request that is sampled only
// while busy is low. The cycle after it is sampled, exactly one of sel_ack or
// sel_err pulses. A request made while busy is high is dropped without any
// response.
module adc_input_select #(
    parameter int NUM_ADC       = 2,
    parameter int ADC_WIDTH     = 14,
    parameter int OUT_WIDTH     = 16,
    parameter int OFFSET_BINARY = 1,
    parameter int MUTE_CYCLES   = 64,
    parameter int OF_HOLD       = 4096,
    localparam int SEL_W        = $clog2(NUM_ADC) | 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_ADC*ADC_WIDTH-1:0] adc_data,
    input  logic [NUM_ADC-1:0]           adc_overrange,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         sel_req,
    output logic                         sel_ack,
    output logic                         sel_err,
    output logic                         busy,
    output logic [SEL_W-1:0]             cur_ch,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         of_flag,
    output logic [ADC_WIDTH-2:0]         peak,
    input  logic                         peak_clear
);

    localparam int MCW = $clog2(MUTE_CYCLES + 1);
    localparam int OFW = $clog2(OF_HOLD + 1);
    localparam logic [SEL_W:0]     NUM_ADC_V = (SEL_W + 1)'(NUM_ADC);
    localparam logic [ADC_WIDTH-1:0] MSB_FLIP =
        (OFFSET_BINARY != 0) ? {1'b1, {(ADC_WIDTH-1){1'b0}}} : '0;

    typedef enum logic {ST_ACTIVE = 1'b0, ST_MUTE = 1'b1} state_t;

    state_t                   state, state_d;
    logic [SEL_W-1:0]         cur_ch_d, pend_ch, pend_ch_d;
    logic [MCW-1:0]           mute_cnt, mute_cnt_d;
    logic                     ack_d, err_d, of_clr, mute_out;
    logic [NUM_ADC*ADC_WIDTH-1:0] adc_q;
    logic [NUM_ADC-1:0]       ovr_q;
    logic [ADC_WIDTH-1:0]     raw, s;
    logic [OUT_WIDTH-1:0]     s_wide;
    logic                     ovr_sel;
    logic [OFW-1:0]           of_cnt;

    // Stage 1: capture all ADC buses and overrange bits every cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            adc_q <= '0;
            ovr_q <= '0;
        end else begin
            adc_q <= adc_data;
            ovr_q <= adc_overrange;
        end
    end

    // FSM state, channel and handshake registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_ACTIVE;
            cur_ch   <= '0;
            pend_ch  <= '0;
            mute_cnt <= '0;
            sel_ack  <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            state    <= state_d;
            cur_ch   <= cur_ch_d;
            pend_ch  <= pend_ch_d;
            mute_cnt <= mute_cnt_d;
            sel_ack  <= ack_d;
            sel_err  <= err_d;
        end
    end

    // Next-state: accept/reject switch requests, count down the mute gap
    always_comb begin
        state_d    = state;
        cur_ch_d   = cur_ch;
        pend_ch_d  = pend_ch;
        mute_cnt_d = mute_cnt;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        of_clr     = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (sel_req) begin
                    if ({1'b0, sel} >= NUM_ADC_V) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        if (sel != cur_ch) begin
                            pend_ch_d  = sel;
                            mute_cnt_d = MCW'(MUTE_CYCLES - 1);
                            state_d    = ST_MUTE;
                        end
                    end
                end
            end
            ST_MUTE: begin
                if (mute_cnt == '0) begin
                    state_d  = ST_ACTIVE;
                    cur_ch_d = pend_ch;
                    of_clr   = 1'b1;
                end else begin
                    mute_cnt_d = mute_cnt - 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    assign busy     = (state == ST_MUTE);
    // Zeros are emitted exactly on the cycles busy is high; the mux looks at
    // the next channel so the new channel's first sample follows the last zero.
    assign mute_out = (state_d == ST_MUTE);

    // Channel mux and format conversion (bounded loop avoids out-of-range index)
    always_comb begin
        raw     = '0;
        ovr_sel = 1'b0;
        for (int k = 0; k < NUM_ADC; k++) begin
            if (cur_ch_d == SEL_W'(k)) raw = adc_q[k*ADC_WIDTH +: ADC_WIDTH];
            if (cur_ch == SEL_W'(k))   ovr_sel = ovr_q[k];
        end
        s      = raw ^ MSB_FLIP;
        s_wide = '0;
        s_wide[OUT_WIDTH-1 -: ADC_WIDTH] = s;
    end

    // Stage 2: output sample register, forced to zero during the mute gap
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         out_data <= '0;
        else if (mute_out) out_data <= '0;
        else               out_data <= s_wide;
    end

    // Overrange stretcher: reload on overrange of the routed channel, else count down
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                of_cnt <= '0;
        else if (of_clr)                          of_cnt <= '0;
        else if (state == ST_ACTIVE && ovr_sel)   of_cnt <= OFW'(OF_HOLD);
        else if (of_cnt != '0)                    of_cnt <= of_cnt - 1'b1;
    end

    assign of_flag = (of_cnt != '0);

`ifdef ADC_PEAK_EN
    localparam logic [ADC_WIDTH-1:0] MOST_NEG = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    logic [ADC_WIDTH-1:0] s_q, s_neg;
    logic                 s_vld;
    logic [ADC_WIDTH-2:0] mag;

    // Delayed copy of the emitted sample so peak follows out_data by one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_q   <= '0;
            s_vld <= 1'b0;
        end else begin
            s_q   <= s;
            s_vld <= !mute_out;
        end
    end

    // Magnitude with the most negative code saturated to the largest positive
    always_comb begin
        s_neg = ~s_q + 1'b1;
        if (s_q == MOST_NEG)         mag = '1;
        else if (s_q[ADC_WIDTH-1])   mag = s_neg[ADC_WIDTH-2:0];
        else                         mag = s_q[ADC_WIDTH-2:0];
    end

    // Peak hold: clear on channel change, clear/load on peak_clear, else track max
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                         peak <= '0;
        else if (cur_ch_d != cur_ch)       peak <= '0;
        else if (peak_clear)               peak <= s_vld ? mag : '0;
        else if (s_vld && mag > peak)      peak <= mag;
    end
`else
    logic unused_peak_clear;
    assign unused_peak_clear = peak_clear;
    assign peak = '0;
`endif

endmodule

// File: tb/tb_adc_input_select.sv
// Testbench for adc_input_select: table-driven conversion vectors plus
// hand-written sequences for switching, overrange stretch, peak hold and reset.
module tb_adc_input_select;

    localparam int NUM_ADC     = 3;
    localparam int ADC_WIDTH   = 14;
    localparam int OUT_WIDTH   = 16;
    localparam int MUTE_CYCLES = 64;
    localparam int OF_HOLD     = 4;
    localparam int SEL_W       = $clog2(NUM_ADC) | 1;

`ifdef ADC_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic                         clock = 1'b0;
    logic                         reset;
    logic [NUM_ADC*ADC_WIDTH-1:0] adc_data;
    logic [NUM_ADC-1:0]           adc_overrange;
    logic [SEL_W-1:0]             sel;
    logic                         sel_req;
    logic                         sel_ack;
    logic                         sel_err;
    logic                         busy;
    logic [SEL_W-1:0]             cur_ch;
    logic [OUT_WIDTH-1:0]         out_data;
    logic                         of_flag;
    logic [ADC_WIDTH-2:0]         peak;
    logic                         peak_clear;

    int checks   = 0;
    int failures = 0;

    adc_input_select #(
        .NUM_ADC(NUM_ADC), .ADC_WIDTH(ADC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .OFFSET_BINARY(1), .MUTE_CYCLES(MUTE_CYCLES), .OF_HOLD(OF_HOLD)
    ) dut (
        .clock(clock), .reset(reset), .adc_data(adc_data),
        .adc_overrange(adc_overrange), .sel(sel), .sel_req(sel_req),
        .sel_ack(sel_ack), .sel_err(sel_err), .busy(busy), .cur_ch(cur_ch),
        .out_data(out_data), .of_flag(of_flag), .peak(peak),
        .peak_clear(peak_clear)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [ADC_WIDTH-1:0] v);
        adc_data[ch*ADC_WIDTH +: ADC_WIDTH] = v;
    endtask

    // Drive overrange mask m at step 0 and at step t1, record of_flag after each edge
    task automatic of_run(input logic [NUM_ADC-1:0] m, input int t1, output logic [11:0] pat);
        for (int k = 0; k < 12; k++) begin
            adc_overrange = (k == 0 || k == t1) ? m : '0;
            step();
            pat[k] = of_flag;
        end
        adc_overrange = '0;
    endtask

    typedef struct {
        logic [ADC_WIDTH-1:0] din;
        logic [OUT_WIDTH-1:0] dout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [11:0] pat;
        int          zeros;
        logic        stray;

        vecs[0] = '{14'h2000, 16'h0000};
        vecs[1] = '{14'h3FFF, 16'h7FFC};
        vecs[2] = '{14'h0000, 16'h8000};
        vecs[3] = '{14'h1FFF, 16'hFFFC};
        vecs[4] = '{14'h2001, 16'h0004};
        vecs[5] = '{14'h1234, 16'hC8D0};

        reset = 1'b1; adc_data = '0; adc_overrange = '1; sel = '0;
        sel_req = 1'b0; peak_clear = 1'b0;
        set_ch(0, 14'h3FFF); set_ch(1, 14'h3000); set_ch(2, 14'h0FFF);
        repeat (3) step();

        // Everything held at zero while reset is high
        check("rst_out", out_data, 0);
        check("rst_ctrl", {sel_ack, sel_err, busy, of_flag}, 0);
        check("rst_cur_ch", cur_ch, 0);
        check("rst_peak", peak, 0);

        reset = 1'b0; adc_overrange = '0;
        set_ch(0, 14'h2000);
        step(); step();
        check("first_zero", out_data, 16'h0000);

        // Conversion table on channel 0, also proving two-cycle latency
        for (int i = 0; i < 6; i++) begin
            set_ch(0, vecs[i].din);
            step();
            if (i > 0) check("latency_hold", out_data, vecs[i-1].dout);
            step();
            check($sformatf("conv_%0d", i), out_data, vecs[i].dout);
        end

        // Switch to channel 1 with a muted gap; requests inside the gap are dropped
        sel = 1; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        check("sw_ack", {sel_ack, sel_err, busy}, 3'b101);
        check("sw_cur_ch_old", cur_ch, 0);
        zeros = (out_data == 0 && busy) ? 1 : 0;
        stray = 1'b0;
        for (int k = 1; k < MUTE_CYCLES; k++) begin
            if (k == 10) begin sel = 2; sel_req = 1'b1; end
            if (k == 20) begin sel = 5; sel_req = 1'b1; end
            step();
            sel_req = 1'b0;
            if (out_data == 0 && busy) zeros++;
            stray = stray | sel_ack | sel_err;
        end
        check("mute_zeros", zeros, MUTE_CYCLES);
        check("mute_no_resp", stray, 0);
        step();
        check("sw_first_ch1", out_data, 16'h4000);
        check("sw_done", {busy, cur_ch}, {1'b0, 3'd1});

        // Same-channel request: ack without mute
        sel = 1; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        check("same_ack", {sel_ack, sel_err, busy}, 3'b100);
        check("same_out", out_data, 16'h4000);

        // Out-of-range selects: error pulse, channel unchanged
        sel = 3; sel_req = 1'b1;
        step();
        check("err_3", {sel_ack, sel_err, busy}, 3'b010);
        sel = 7;
        step();
        sel_req = 1'b0;
        check("err_7", {sel_err, cur_ch}, {1'b1, 3'd1});
        step();
        check("err_pulse", sel_err, 0);

        // Overrange stretch on the routed channel (1)
        of_run(3'b010, -1, pat);
        check("of_single", pat, 12'h01E);
        of_run(3'b010, 4, pat);
        check("of_retrigger", pat, 12'h1FE);
        of_run(3'b101, 4, pat);
        check("of_other_ch", pat, 12'h000);

        // Peak hold on channel 1 (tied to zero when the feature is not built)
        set_ch(1, 14'h2000);
        repeat (3) step();
        peak_clear = 1'b1; step(); peak_clear = 1'b0;
        check("peak_clr0", peak, 0);
        set_ch(1, 14'h1F9C); repeat (3) step();
        check("peak_m100", peak, PEAK_ON ? 100 : 0);
        set_ch(1, 14'h2032); repeat (3) step();
        check("peak_p50", peak, PEAK_ON ? 100 : 0);
        set_ch(1, 14'h0000); repeat (3) step();
        check("peak_mneg", peak, PEAK_ON ? 8191 : 0);
        set_ch(1, 14'h2003); step(); step();
        check("peak_p3_out", out_data, 16'h000C);
        peak_clear = 1'b1; step(); peak_clear = 1'b0;
        check("peak_clr_load", peak, PEAK_ON ? 3 : 0);

        // Asynchronous reset in the middle of a mute gap
        sel = 0; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        repeat (10) step();
        check("mid_mute_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst", {busy, sel_ack, sel_err, of_flag}, 0);
        check("async_rst_ch", cur_ch, 0);
        check("async_rst_out", out_data, 0);
        step(); step();
        check("rst_hold", {out_data, peak}, 0);
        reset = 1'b0;
        set_ch(0, 14'h3FFF);
        step(); step();
        check("post_rst_out", out_data, 16'h7FFC);
        check("post_rst_state", {busy, cur_ch}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
